// File: rtl/seven_segment_driver_pkg.sv
// Shared constants and types for the multiplexed four-digit seven-segment driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package seven_segment_driver_pkg;

  localparam int NumDigits = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SegZero  = 7'b1000000;
  localparam seg_t SegOne   = 7'b1111001;
  localparam seg_t SegTwo   = 7'b0100100;
  localparam seg_t SegThree = 7'b0110000;
  localparam seg_t SegFour  = 7'b0011001;
  localparam seg_t SegFive  = 7'b0010010;
  localparam seg_t SegSix   = 7'b0000010;
  localparam seg_t SegSeven = 7'b1111000;
  localparam seg_t SegEight = 7'b0000000;
  localparam seg_t SegNine  = 7'b0010000;
  localparam seg_t SegDash  = 7'b0111111;
  localparam seg_t SegBlank = 7'b1111111;

endpackage

// File: rtl/seven_segment_driver_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
  import seven_segment_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  always_comb begin
    seg = SegDash;
    case (bcd)
      4'd0: seg = SegZero;
      4'd1: seg = SegOne;
      4'd2: seg = SegTwo;
      4'd3: seg = SegThree;
      4'd4: seg = SegFour;
      4'd5: seg = SegFive;
      4'd6: seg = SegSix;
      4'd7: seg = SegSeven;
      4'd8: seg = SegEight;
      4'd9: seg = SegNine;
      default: seg = SegDash;
    endcase
  end

endmodule

// File: rtl/seven_segment_driver.sv
// Time-multiplexed four-digit seven-segment driver with per-slot dead time,
// leading-zero blanking and decimal points; all outputs registered, active-low.
module seven_segment_driver
  import seven_segment_driver_pkg::*;
#(
  parameter int CounterWidth = 2,
  parameter int RefreshTime  = 4,
  parameter int BlankTime    = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  input  logic [3:0]  DpIn,
  input  logic        LzbEnable,
  output logic [3:0]  AnodeOut,
  output seg_t        SegOut,
  output logic        DpOut
);

  localparam logic [CounterWidth-1:0] CntLast  = CounterWidth'(RefreshTime - 1);
  localparam logic [CounterWidth-1:0] CntBlank = CounterWidth'(BlankTime);

  // cnt/idx name the slot cycle whose outputs are produced on the coming edge
  logic [CounterWidth-1:0] cnt;
  logic [1:0]              idx;
  logic [3:0]              nibble;
  seg_t                    dec_seg;
  logic [NumDigits-1:0]    blank;
  logic [3:0]              anode_on;

  always_comb begin
    nibble   = DataIn[{idx, 2'b00} +: 4];
    anode_on = ~(4'b0001 << idx);
  end

  // A digit blanks only if it and every more significant digit are zero
  always_comb begin
    blank    = '0;
    blank[3] = LzbEnable && (DataIn[15:12] == 4'd0);
    blank[2] = blank[3] && (DataIn[11:8] == 4'd0);
    blank[1] = blank[2] && (DataIn[7:4] == 4'd0);
    blank[0] = 1'b0;
  end

  bcd_to_seg u_dec (
    .bcd (nibble),
    .seg (dec_seg)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt      <= '0;
      idx      <= 2'd0;
      AnodeOut <= 4'b1111;
      SegOut   <= SegBlank;
      DpOut    <= 1'b1;
    end else begin
      if (cnt == CntLast) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      AnodeOut <= (cnt < CntBlank) ? 4'b1111 : anode_on;

      // Inputs are captured only on the first cycle of a slot and then held
      if (cnt == '0) begin
        SegOut <= blank[idx] ? SegBlank : dec_seg;
        DpOut  <= ~DpIn[idx];
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_driver.sv
// Directed-vector bench for seven_segment_driver (CounterWidth=2, RefreshTime=4, BlankTime=1).
module tb_seven_segment_driver;

  logic        Clk;
  logic        Reset;
  logic [15:0] DataIn;
  logic [3:0]  DpIn;
  logic        LzbEnable;
  logic [3:0]  AnodeOut;
  logic [6:0]  SegOut;
  logic        DpOut;

  int errors;
  int checks;

  seven_segment_driver #(
    .CounterWidth (2),
    .RefreshTime  (4),
    .BlankTime    (1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .DpIn      (DpIn),
    .LzbEnable (LzbEnable),
    .AnodeOut  (AnodeOut),
    .SegOut    (SegOut),
    .DpOut     (DpOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reset for one edge; after return the next rising edge is cycle 0.
  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    DataIn    = 16'h1234;
    DpIn      = 4'b1111;
    LzbEnable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      checks++;
      if (AnodeOut !== 4'b1111) begin
        errors++;
        $display("FAIL reset_anode cycle %0d got %b want 1111", c, AnodeOut);
      end
      checks++;
      if (SegOut !== 7'b1111111) begin
        errors++;
        $display("FAIL reset_seg cycle %0d got %b want 1111111", c, SegOut);
      end
      checks++;
      if (DpOut !== 1'b1) begin
        errors++;
        $display("FAIL reset_dp cycle %0d got %b want 1", c, DpOut);
      end
    end
    Reset = 1'b0;
  endtask

  // Runs two full refresh rounds; exp_seg[k]/exp_dp[k] are the hand-decoded digit-k values.
  task automatic test_pattern(input logic [15:0] data, input logic [3:0] dp, input logic lzb,
                              input logic [3:0][6:0] exp_seg, input logic [3:0] exp_dp,
                              input string name);
    int slot;
    int sc;
    logic [3:0] exp_an;
    DataIn    = data;
    DpIn      = dp;
    LzbEnable = lzb;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      @(negedge Clk);
      slot   = (c / 4) % 4;
      sc     = c % 4;
      exp_an = (sc == 0) ? 4'b1111 : ~(4'b0001 << slot);
      checks++;
      if (AnodeOut !== exp_an) begin
        errors++;
        $display("FAIL %s_anode cycle %0d got %b want %b", name, c, AnodeOut, exp_an);
      end
      checks++;
      if (SegOut !== exp_seg[slot]) begin
        errors++;
        $display("FAIL %s_seg cycle %0d got %b want %b", name, c, SegOut, exp_seg[slot]);
      end
      checks++;
      if (DpOut !== exp_dp[slot]) begin
        errors++;
        $display("FAIL %s_dp cycle %0d got %b want %b", name, c, DpOut, exp_dp[slot]);
      end
    end
  endtask

  task automatic test_count();
    test_pattern(16'h1234, 4'b0000, 1'b0,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111, "count1234");
  endtask

  task automatic test_lzb();
    test_pattern(16'h0070, 4'b0000, 1'b1,
                 {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b1111, "lzb_on");
    test_pattern(16'h0070, 4'b0000, 1'b0,
                 {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1111, "lzb_off");
    test_pattern(16'h1004, 4'b0000, 1'b1,
                 {7'b1111001, 7'b1000000, 7'b1000000, 7'b0011001}, 4'b1111, "lzb_inner0");
    test_pattern(16'h0000, 4'b0000, 1'b1,
                 {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111, "lzb_all0");
  endtask

  task automatic test_dash_dp();
    test_pattern(16'h00A0, 4'b0010, 1'b0,
                 {7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000}, 4'b1101, "dash_dp");
    test_pattern(16'h00F0, 4'b1000, 1'b1,
                 {7'b1111111, 7'b1111111, 7'b0111111, 7'b1000000}, 4'b0111, "dp_on_blank");
  endtask

  task automatic test_midslot_change();
    logic [6:0] exp_seg;
    DataIn    = 16'h0000;
    DpIn      = 4'b0000;
    LzbEnable = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      exp_seg = (c < 4) ? 7'b1000000 : 7'b0010000;
      checks++;
      if (SegOut !== exp_seg) begin
        errors++;
        $display("FAIL midslot_seg cycle %0d got %b want %b", c, SegOut, exp_seg);
      end
      if (c == 1) DataIn = 16'h9999;
    end
  endtask

  task automatic test_reset_midslot();
    DataIn    = 16'h1234;
    DpIn      = 4'b0000;
    LzbEnable = 1'b0;
    do_reset();
    repeat (10) @(negedge Clk);
    checks++;
    if (AnodeOut !== 4'b1011) begin
      errors++;
      $display("FAIL rstmid_pre_anode got %b want 1011", AnodeOut);
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++;
    if (AnodeOut !== 4'b1111 || SegOut !== 7'b1111111 || DpOut !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reset got %b/%b/%b want 1111/1111111/1", AnodeOut, SegOut, DpOut);
    end
    @(negedge Clk);
    checks++;
    if (AnodeOut !== 4'b1111 || SegOut !== 7'b0011001) begin
      errors++;
      $display("FAIL rstmid_c0 got %b/%b want 1111/0011001", AnodeOut, SegOut);
    end
    @(negedge Clk);
    checks++;
    if (AnodeOut !== 4'b1110 || SegOut !== 7'b0011001) begin
      errors++;
      $display("FAIL rstmid_c1 got %b/%b want 1110/0011001", AnodeOut, SegOut);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    Reset     = 1'b1;
    DataIn    = 16'h0000;
    DpIn      = 4'b0000;
    LzbEnable = 1'b0;
    @(negedge Clk);
    test_reset();
    test_count();
    test_lzb();
    test_dash_dp();
    test_midslot_change();
    test_reset_midslot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
